sha512_pad: RTL and testbench



---
 rtl/sha512_pad.sv | 135 +++++++++++++
 tb/tb_sha512_pad.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sha512_pad.sv
// rtl/sha512_pad.sv - SHA-512 message padder producing 1024-bit chunks (optional SHA512_PAD_STRICT_EN)
module sha512_pad #(
    parameter int LEN_W = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          chunk_valid,
    input  logic          chunk_ready,
    output logic [1023:0] chunk,
    output logic          chunk_first,
    output logic          chunk_last,
    output logic          err
);
    typedef enum logic [1:0] {FILL, EMIT, EMIT_FINAL, EMIT_EXTRA} state_t;

    state_t           state, state_next;
    logic [3:0]       idx;
    logic [LEN_W-1:0] byte_count;
    logic [1023:0]    buffer;
    logic             first_flag;
    logic             pad_pending;

    logic             accept;
    logic             handshake;
    logic [3:0]       eff_bytes;
    logic [3:0]       idx_inc;
    logic [7:0]       u;
    logic [63:0]      masked;
    logic [LEN_W-1:0] count_next;
    logic [127:0]     len_next;
    logic [127:0]     len_cur;
    logic [1023:0]    fill_buf;
    logic [1023:0]    extra_buf;

    assign in_ready    = (state == FILL) && reset;
    assign accept      = in_valid && in_ready;
    assign chunk_valid = (state != FILL);
    assign handshake   = chunk_valid && chunk_ready;
    assign chunk       = buffer;
    assign chunk_first = chunk_valid && first_flag;
    assign chunk_last  = (state == EMIT_FINAL);
    assign idx_inc     = idx + 4'd1;

    // Build the buffer contents that result from accepting the current word.
    always_comb begin
        eff_bytes = 4'd8;
        if (in_last)
            eff_bytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        masked = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(eff_bytes))
                masked[63-8*k -: 8] = in_data[63-8*k -: 8];
        end
        if (in_last && eff_bytes < 4'd8)
            masked = masked | (64'h80 << (8 * (4'd7 - eff_bytes)));
        u          = {1'b0, idx, 3'b000} + {4'b0000, eff_bytes};
        count_next = byte_count + LEN_W'(eff_bytes);
        len_next   = {{(125-LEN_W){1'b0}}, count_next, 3'b000};
        len_cur    = {{(125-LEN_W){1'b0}}, byte_count, 3'b000};
        fill_buf   = buffer;
        fill_buf[64*(15-idx) +: 64] = masked;
        if (in_last && eff_bytes == 4'd8 && idx != 4'd15)
            fill_buf[64*(15-idx_inc) +: 64] = 64'h8000_0000_0000_0000;
        if (in_last && u <= 8'd111)
            fill_buf[127:0] = len_next;
        extra_buf            = '0;
        extra_buf[1023:960]  = pad_pending ? 64'h8000_0000_0000_0000 : 64'h0;
        extra_buf[127:0]     = len_cur;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (in_last)
                        state_next = (u <= 8'd111) ? EMIT_FINAL : EMIT_EXTRA;
                    else if (idx == 4'd15)
                        state_next = EMIT;
                end
            end
            EMIT:       if (chunk_ready) state_next = FILL;
            EMIT_FINAL: if (chunk_ready) state_next = FILL;
            EMIT_EXTRA: if (chunk_ready) state_next = EMIT_FINAL;
            default:    state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FILL;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            byte_count  <= '0;
            buffer      <= '0;
            first_flag  <= 1'b1;
            pad_pending <= 1'b0;
        end else if (accept) begin
            buffer     <= fill_buf;
            byte_count <= count_next;
            if (!in_last && idx != 4'd15)
                idx <= idx_inc;
            if (in_last)
                pad_pending <= (u == 8'd128);
        end else if (handshake) begin
            idx        <= '0;
            first_flag <= (state == EMIT_FINAL);
            buffer     <= (state == EMIT_EXTRA) ? extra_buf : '0;
            if (state == EMIT_FINAL)
                byte_count <= '0;
        end
    end

`ifdef SHA512_PAD_STRICT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (accept && ((in_bytes > 4'd8) || (!in_last && in_bytes != 4'd8)))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha512_pad.sv
// tb/tb_sha512_pad.sv - directed self-checking bench for sha512_pad
module tb_sha512_pad;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic [3:0]    in_bytes = '0;
    logic          chunk_valid;
    logic          chunk_ready = 1'b0;
    logic [1023:0] chunk;
    logic          chunk_first;
    logic          chunk_last;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0]   ew [16];
    logic [1023:0] cw;
    logic          cf, cl;
    logic [1023:0] saved;

    sha512_pad dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .chunk(chunk),
        .chunk_first(chunk_first), .chunk_last(chunk_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input int i);
        return {32'hDEAD_0000 | 32'(i), 32'hBEEF_0000 | 32'(i)};
    endfunction

    task automatic clear_ew();
        for (int j = 0; j < 16; j++) ew[j] = '0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic get_chunk(input string tag);
        int n = 0;
        @(negedge clk);
        while (!chunk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!chunk_valid) begin
            check({tag, "_timeout"}, 64'(chunk_valid), 64'd1);
            cw = '0; cf = 1'b0; cl = 1'b0;
        end else begin
            cw = chunk; cf = chunk_first; cl = chunk_last;
            chunk_ready = 1'b1;
            @(posedge clk);
            #1;
            chunk_ready = 1'b0;
        end
    endtask

    task automatic check_chunk(input string tag, input logic f, input logic l);
        for (int j = 0; j < 16; j++)
            check($sformatf("%s_w%0d", tag, j), cw[64*(15-j) +: 64], ew[j]);
        check({tag, "_first"}, 64'(cf), 64'(f));
        check({tag, "_last"}, 64'(cl), 64'(l));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_valid", 64'(chunk_valid), 64'd0);
        check("rst_chunk", 64'(|chunk), 64'd0);
        check("rst_first", 64'(chunk_first), 64'd0);
        check("rst_last", 64'(chunk_last), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Empty message; also checks one-cycle latency to chunk_valid
        send_word(64'h0, 1'b1, 4'd0);
        check("empty_latency", 64'(chunk_valid), 64'd1);
        get_chunk("empty");
        clear_ew(); ew[0] = 64'h8000_0000_0000_0000;
        check_chunk("empty", 1'b1, 1'b1);

        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        get_chunk("abc");
        clear_ew(); ew[0] = 64'h6162_6380_0000_0000; ew[15] = 64'h18;
        check_chunk("abc", 1'b1, 1'b1);

        // 112 bytes: marker spills into word 14, length needs an extra chunk
        for (int i = 0; i < 14; i++) send_word(wdat(i), i == 13, 4'd8);
        get_chunk("m112a");
        clear_ew();
        for (int i = 0; i < 14; i++) ew[i] = wdat(i);
        ew[14] = 64'h8000_0000_0000_0000;
        check_chunk("m112a", 1'b1, 1'b0);
        get_chunk("m112b");
        clear_ew(); ew[15] = 64'h380;
        check_chunk("m112b", 1'b0, 1'b1);

        // 111 bytes: marker in last byte of word 13, length fits
        for (int i = 0; i < 14; i++) send_word(wdat(i), i == 13, (i == 13) ? 4'd7 : 4'd8);
        get_chunk("m111");
        clear_ew();
        for (int i = 0; i < 13; i++) ew[i] = wdat(i);
        ew[13] = (wdat(13) & 64'hFFFF_FFFF_FFFF_FF00) | 64'h80;
        ew[15] = 64'h378;
        check_chunk("m111", 1'b1, 1'b1);

        for (int i = 0; i < 16; i++) send_word(wdat(i + 20), i == 15, 4'd8);
        get_chunk("m128a");
        clear_ew();
        for (int i = 0; i < 16; i++) ew[i] = wdat(i + 20);
        check_chunk("m128a", 1'b1, 1'b0);
        get_chunk("m128b");
        clear_ew(); ew[0] = 64'h8000_0000_0000_0000; ew[15] = 64'h400;
        check_chunk("m128b", 1'b0, 1'b1);

        // Backpressure: chunk and flags held, no input accepted
        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        saved = chunk;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(chunk_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_chunk_same", 64'(chunk == saved), 64'd1);
            check("stall_first", 64'(chunk_first), 64'd1);
            check("stall_last", 64'(chunk_last), 64'd1);
        end
        check("stall_word0", saved[1023:960], 64'h6162_6380_0000_0000);
        @(negedge clk);
        chunk_ready = 1'b1;
        @(posedge clk);
        #1;
        chunk_ready = 1'b0;
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_valid", 64'(chunk_valid), 64'd0);

        // Reset mid-message discards the partial chunk
        for (int i = 0; i < 5; i++) send_word(wdat(i), 1'b0, 4'd8);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_chunk", 64'(|chunk), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        get_chunk("rst_abc");
        clear_ew(); ew[0] = 64'h6162_6380_0000_0000; ew[15] = 64'h18;
        check_chunk("rst_abc", 1'b1, 1'b1);

        // Non-last word with a short byte count
        send_word(wdat(1), 1'b0, 4'd3);
`ifdef SHA512_PAD_STRICT_EN
        check("strict_err_set", 64'(err), 64'd1);
        send_word(wdat(2), 1'b1, 4'd8);
        get_chunk("strict");
        check("strict_err_hold", 64'(err), 64'd1);
        clear_ew(); ew[0] = wdat(1); ew[1] = wdat(2);
        ew[2] = 64'h8000_0000_0000_0000; ew[15] = 64'h80;
        check_chunk("strict", 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("strict_err_clear", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
`else
        check("nostrict_err", 64'(err), 64'd0);
        send_word(wdat(2), 1'b1, 4'd8);
        get_chunk("nostrict");
        clear_ew(); ew[0] = wdat(1); ew[1] = wdat(2);
        ew[2] = 64'h8000_0000_0000_0000; ew[15] = 64'h80;
        check_chunk("nostrict", 1'b1, 1'b1);
`endif

        // Oversized in_bytes on a last word is clamped to 8
        send_word(wdat(7), 1'b1, 4'd12);
        get_chunk("clamp");
        clear_ew(); ew[0] = wdat(7); ew[1] = 64'h8000_0000_0000_0000; ew[15] = 64'h40;
        check_chunk("clamp", 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
